// File: rtl/cfg_pkg.sv
// Shared types for the configuration dispatcher: field widths, the layer
// descriptor as it sits in the FIFO, and the issue FSM state encoding.
package cfg_pkg;

  localparam int DATA_CWIDTH = 64;
  localparam int WICP_CWIDTH = 64;
  localparam int TMPC_CWIDTH = 32;
  localparam int POST_CWIDTH = 32;

  typedef struct packed {
    logic [DATA_CWIDTH-1:0] data;
    logic [WICP_CWIDTH-1:0] wicp;
    logic [TMPC_CWIDTH-1:0] tmpc;
    logic [POST_CWIDTH-1:0] post;
  } cfg_desc_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } disp_state_e;

endpackage

// File: rtl/cfg_desc_fifo.sv
// Synchronous descriptor FIFO. full/empty are decoded from the registered
// occupancy count; a push while full or a pop while empty is ignored.
module cfg_desc_fifo
  import cfg_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  logic      pop,
  input  cfg_desc_t din,
  output logic      full,
  output logic      empty,
  output cfg_desc_t head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  cfg_desc_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cfg_dispatcher.sv
// Initiator end of the accelerator cfg_valid/cfg_busy port: buffers host
// descriptors, issues one per run, waits for the accelerator to pick it up
// (busy rising) and to finish (busy falling), counts completed layers and
// flags a sticky error when the pick-up never comes.
module cfg_dispatcher
  import cfg_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 16,
  parameter int CWIDTH      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   desc_valid,
  output logic                   desc_ready,
  input  logic [DATA_CWIDTH-1:0] desc_data,
  input  logic [WICP_CWIDTH-1:0] desc_wicp,
  input  logic [TMPC_CWIDTH-1:0] desc_tmpc,
  input  logic [POST_CWIDTH-1:0] desc_post,
  input  logic                   enable,
  input  logic                   err_clear,
  output logic                   cfg_valid,
  output logic [DATA_CWIDTH-1:0] cfg_data_data,
  output logic [WICP_CWIDTH-1:0] cfg_wicp_data,
  output logic [TMPC_CWIDTH-1:0] cfg_tmpc_data,
  output logic [POST_CWIDTH-1:0] cfg_post_data,
  input  logic                   cfg_busy,
  output logic [CWIDTH-1:0]      layer_cnt,
  output logic                   layer_done,
  output logic                   idle,
  output logic                   ack_timeout
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);

  disp_state_e   state_q;
  disp_state_e   state_d;
  cfg_desc_t     desc_in;
  cfg_desc_t     fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          timeout_hit;
  logic          done_hit;
  logic [TW-1:0] to_cnt;

  assign desc_in.data = desc_data;
  assign desc_in.wicp = desc_wicp;
  assign desc_in.tmpc = desc_tmpc;
  assign desc_in.post = desc_post;

  assign push       = desc_valid && !fifo_full;
  assign desc_ready = !fifo_full;
  assign cfg_valid  = (state_q == ISSUE);
  assign idle       = (state_q == IDLE) && fifo_empty;

  cfg_desc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (desc_in),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // Next-state logic; a busy accelerator or a pending error blocks issue.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    timeout_hit = 1'b0;
    done_hit    = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && !fifo_empty && !cfg_busy && !ack_timeout) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT_ACK;
      WAIT_ACK: begin
        if (cfg_busy) begin
          state_d = WAIT_DONE;
        end else if (to_cnt == TO_LAST) begin
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!cfg_busy) begin
          done_hit = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any run in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Descriptor output registers, loaded on pop and held until the next issue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_data_data <= '0;
      cfg_wicp_data <= '0;
      cfg_tmpc_data <= '0;
      cfg_post_data <= '0;
    end else if (pop) begin
      cfg_data_data <= fifo_head.data;
      cfg_wicp_data <= fifo_head.wicp;
      cfg_tmpc_data <= fifo_head.tmpc;
      cfg_post_data <= fifo_head.post;
    end
  end

  // Counts WAIT_ACK cycles spent without busy; restarted by every strobe.
  always_ff @(posedge clk) begin
    if (!rst_n)                              to_cnt <= '0;
    else if (state_q == ISSUE)               to_cnt <= '0;
    else if (state_q == WAIT_ACK && !cfg_busy) to_cnt <= to_cnt + 1'b1;
  end

  // Sticky timeout flag; a clear wins over a timeout in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n)           ack_timeout <= 1'b0;
    else if (err_clear)   ack_timeout <= 1'b0;
    else if (timeout_hit) ack_timeout <= 1'b1;
  end

  // Completion pulse and wrapping layer counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      layer_cnt  <= '0;
      layer_done <= 1'b0;
    end else begin
      layer_done <= done_hit;
      if (done_hit) layer_cnt <= layer_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_cfg_dispatcher.sv
// Bench for cfg_dispatcher: directed descriptors go into a scoreboard as they
// are pushed; a monitor compares every strobe and completion against it. A
// second instance with a 2-bit layer counter shares all inputs.
module tb_cfg_dispatcher;
  import cfg_pkg::*;

  logic                   clk;
  logic                   rst_n;
  logic                   desc_valid;
  logic [DATA_CWIDTH-1:0] desc_data;
  logic [WICP_CWIDTH-1:0] desc_wicp;
  logic [TMPC_CWIDTH-1:0] desc_tmpc;
  logic [POST_CWIDTH-1:0] desc_post;
  logic                   enable;
  logic                   err_clear;
  logic                   cfg_busy;

  logic                   desc_ready;
  logic                   cfg_valid;
  logic [DATA_CWIDTH-1:0] cfg_data_data;
  logic [WICP_CWIDTH-1:0] cfg_wicp_data;
  logic [TMPC_CWIDTH-1:0] cfg_tmpc_data;
  logic [POST_CWIDTH-1:0] cfg_post_data;
  logic [15:0]            layer_cnt;
  logic                   layer_done;
  logic                   idle;
  logic                   ack_timeout;

  logic                   w_desc_ready;
  logic                   w_cfg_valid;
  logic [DATA_CWIDTH-1:0] w_cfg_data_data;
  logic [WICP_CWIDTH-1:0] w_cfg_wicp_data;
  logic [TMPC_CWIDTH-1:0] w_cfg_tmpc_data;
  logic [POST_CWIDTH-1:0] w_cfg_post_data;
  logic [1:0]             w_layer_cnt;
  logic                   w_layer_done;
  logic                   w_idle;
  logic                   w_ack_timeout;

  logic acc_on;
  logic busy_model;
  logic busy_force;
  assign cfg_busy = acc_on ? busy_model : busy_force;

  int checks    = 0;
  int errors    = 0;
  int issue_cnt = 0;
  int done_seen = 0;
  int exp_layer = 0;
  cfg_desc_t exp_desc[$];
  int        exp_cnt[$];

  cfg_dispatcher u_dut (
    .clk(clk), .rst_n(rst_n), .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_data(desc_data), .desc_wicp(desc_wicp), .desc_tmpc(desc_tmpc),
    .desc_post(desc_post), .enable(enable), .err_clear(err_clear),
    .cfg_valid(cfg_valid), .cfg_data_data(cfg_data_data),
    .cfg_wicp_data(cfg_wicp_data), .cfg_tmpc_data(cfg_tmpc_data),
    .cfg_post_data(cfg_post_data), .cfg_busy(cfg_busy), .layer_cnt(layer_cnt),
    .layer_done(layer_done), .idle(idle), .ack_timeout(ack_timeout)
  );

  cfg_dispatcher #(.CWIDTH(2)) u_wrap (
    .clk(clk), .rst_n(rst_n), .desc_valid(desc_valid), .desc_ready(w_desc_ready),
    .desc_data(desc_data), .desc_wicp(desc_wicp), .desc_tmpc(desc_tmpc),
    .desc_post(desc_post), .enable(enable), .err_clear(err_clear),
    .cfg_valid(w_cfg_valid), .cfg_data_data(w_cfg_data_data),
    .cfg_wicp_data(w_cfg_wicp_data), .cfg_tmpc_data(w_cfg_tmpc_data),
    .cfg_post_data(w_cfg_post_data), .cfg_busy(cfg_busy), .layer_cnt(w_layer_cnt),
    .layer_done(w_layer_done), .idle(w_idle), .ack_timeout(w_ack_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Accelerator model: busy rises 3 cycles after the strobe, held 10 cycles.
  initial begin
    busy_model = 1'b0;
    forever begin
      @(negedge clk);
      if (cfg_valid && acc_on) begin
        repeat (3) @(negedge clk);
        busy_model = 1'b1;
        repeat (10) @(negedge clk);
        busy_model = 1'b0;
      end
    end
  end

  // Monitor: every strobe and every completion is checked against the scoreboard.
  initial begin
    cfg_desc_t got;
    cfg_desc_t want;
    int e;
    forever begin
      @(negedge clk);
      if (cfg_valid) begin
        issue_cnt++;
        checks++;
        got = {cfg_data_data, cfg_wicp_data, cfg_tmpc_data, cfg_post_data};
        if (exp_desc.size() == 0) begin
          errors++;
          $display("FAIL issue_unexpected got=%h", got);
        end else begin
          want = exp_desc.pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL issue_desc got=%h want=%h", got, want);
          end
        end
      end
      if (layer_done) begin
        done_seen++;
        checks++;
        if (exp_cnt.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected got layer_cnt=%0d", layer_cnt);
        end else begin
          e = exp_cnt.pop_front();
          if (layer_cnt !== 16'(e) || w_layer_cnt !== 2'(e % 4)) begin
            errors++;
            $display("FAIL layer_cnt got=%0d/%0d want=%0d/%0d",
                     layer_cnt, w_layer_cnt, e, e % 4);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic cfg_desc_t mk(input int i);
    cfg_desc_t d;
    d.data = 64'hDA7A_0000_0000_0000 + 64'(i);
    d.wicp = 64'h01C0_0000_0000_0000 + 64'(i);
    d.tmpc = 32'hC000_0000 + 32'(i);
    d.post = 32'hB000_0000 + 32'(i);
    return d;
  endfunction

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic push(input cfg_desc_t d, input bit exp_issue, input bit exp_done);
    int n;
    desc_valid = 1'b1;
    desc_data  = d.data;
    desc_wicp  = d.wicp;
    desc_tmpc  = d.tmpc;
    desc_post  = d.post;
    n = 0;
    while (!desc_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!desc_ready) begin
      checks++;
      errors++;
      $display("FAIL push_wait got=not_ready want=ready");
      desc_valid = 1'b0;
      return;
    end
    @(negedge clk);
    desc_valid = 1'b0;
    if (exp_issue) exp_desc.push_back(d);
    if (exp_done) begin
      exp_layer++;
      exp_cnt.push_back(exp_layer);
    end
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_seen < target && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("done_wait", done_seen, target);
  endtask

  task automatic wait_strobe(input string name);
    int n;
    n = 0;
    while (!cfg_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(name, cfg_valid, 1);
  endtask

  initial begin
    int n;
    bit seen;
    cfg_desc_t d0;
    rst_n = 1'b0; desc_valid = 1'b0; enable = 1'b0; err_clear = 1'b0;
    desc_data = '0; desc_wicp = '0; desc_tmpc = '0; desc_post = '0;
    acc_on = 1'b1; busy_force = 1'b0;

    // 1. reset values
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_cfg_valid", cfg_valid, 0);
    check("rst_cfg_data", cfg_data_data, 0);
    check("rst_cfg_wicp", cfg_wicp_data, 0);
    check("rst_cfg_tmpc", cfg_tmpc_data, 0);
    check("rst_cfg_post", cfg_post_data, 0);
    check("rst_layer_cnt", layer_cnt, 0);
    check("rst_layer_done", layer_done, 0);
    check("rst_ack_timeout", ack_timeout, 0);
    check("rst_idle", idle, 1);
    check("rst_desc_ready", desc_ready, 1);

    // 2. single layer, strobe two cycles after the push
    enable = 1'b1;
    d0.data = 64'hA5; d0.wicp = 64'h1; d0.tmpc = 32'h2; d0.post = 32'h3;
    push(d0, 1, 1);
    check("latency_no_strobe_yet", cfg_valid, 0);
    @(negedge clk);
    check("latency_strobe", cfg_valid, 1);
    check("strobe_data", cfg_data_data, 64'hA5);
    wait_done(1);
    check("single_layer_cnt", layer_cnt, 1);

    // 3. back-pressure: fill with enable low, fifth push is held
    enable = 1'b0;
    for (int i = 1; i <= 4; i++) push(mk(i), 1, 1);
    check("full_desc_ready", desc_ready, 0);
    check("full_not_idle", idle, 0);
    d0 = mk(5);
    desc_valid = 1'b1;
    desc_data = d0.data; desc_wicp = d0.wicp; desc_tmpc = d0.tmpc; desc_post = d0.post;
    repeat (3) @(negedge clk);
    check("held_desc_ready", desc_ready, 0);
    check("disabled_no_issue", issue_cnt, 1);
    enable = 1'b1;
    push(mk(5), 1, 1);
    wait_done(6);
    check("backpressure_layer_cnt", layer_cnt, 6);
    check("backpressure_wrap_cnt", w_layer_cnt, 2);

    // 4. acknowledge timeout, blocked issue, then err_clear resumes
    acc_on = 1'b0;
    push(mk(6), 1, 0);
    wait_strobe("timeout_strobe");
    n = 0;
    while (!ack_timeout && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("timeout_latency", n, 17);
    check("timeout_idle", idle, 1);
    push(mk(7), 1, 1);
    repeat (8) @(negedge clk);
    check("timeout_blocks_issue", issue_cnt, 7);
    check("timeout_sticky", ack_timeout, 1);
    check("timeout_pending_not_idle", idle, 0);
    acc_on = 1'b1;
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    check("err_clear", ack_timeout, 0);
    wait_done(7);
    check("resume_layer_cnt", layer_cnt, 7);

    // err_clear held through a timeout keeps the flag low
    acc_on = 1'b0;
    err_clear = 1'b1;
    push(mk(8), 1, 0);
    wait_strobe("prio_strobe");
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ack_timeout) seen = 1'b1;
    end
    check("clear_priority", seen, 0);
    check("clear_priority_idle", idle, 1);
    err_clear = 1'b0;

    // busy glitch in IDLE is ignored, busy high blocks issue
    busy_force = 1'b1;
    @(negedge clk);
    check("glitch_idle", idle, 1);
    check("glitch_no_done", layer_done, 0);
    push(mk(9), 1, 1);
    repeat (5) @(negedge clk);
    check("busy_blocks_issue", issue_cnt, 9);
    busy_force = 1'b0;
    acc_on = 1'b1;
    wait_done(8);
    check("glitch_layer_cnt", layer_cnt, 8);

    // 5. reset in WAIT_DONE abandons the run and empties the FIFO
    push(mk(10), 1, 0);
    n = 0;
    while (!cfg_busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("midrun_busy", cfg_busy, 1);
    repeat (2) @(negedge clk);
    push(mk(11), 0, 0);
    check("midrun_not_idle", idle, 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_layer = 0;
    check("midrun_idle", idle, 1);
    check("midrun_layer_cnt", layer_cnt, 0);
    check("midrun_wrap_cnt", w_layer_cnt, 0);
    check("midrun_desc_ready", desc_ready, 1);
    check("midrun_cfg_data", cfg_data_data, 0);
    repeat (15) @(negedge clk);
    check("midrun_no_done", done_seen, 8);
    check("midrun_no_reissue", issue_cnt, 11);

    // 6. counter wrap on the 2-bit instance, FIFO order preserved
    for (int i = 12; i <= 16; i++) push(mk(i), 1, 1);
    wait_done(13);
    check("wrap_layer_cnt", layer_cnt, 5);
    check("wrap_small_cnt", w_layer_cnt, 1);
    repeat (3) @(negedge clk);
    check("sb_desc_drained", exp_desc.size(), 0);
    check("sb_cnt_drained", exp_cnt.size(), 0);
    check("final_idle", idle, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
